shifter_pipe: RTL and testbench

- Pipelined, parametrised barrel shifter; successor to the single-cycle combinational shifter.
- Four modes: logical left, logical right, arithmetic right, rotate left.
- Valid/ready handshake on both sides with per-stage bubble collapse; sustains one result per clock.
- Sits between the datapath register file and arithmetic units wherever shift width or fmax outgrows the combinational version.

---
 rtl/shifter_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_shifter_pipe.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe.sv
// -----------------------------------------------------------------------------
// shifter_pipe
//
// Pipelined barrel shifter with LOG_W register stages. Stage k performs the
// 2^k shift when bit k of the shift amount is set. Stage 0 also resolves
// saturation (in_amt >= DATA_W) before its own shift. The output is driven
// straight from the last stage's registers.
//
// Modes (in_mode): 00 LSL, 01 LSR, 10 ASR, 11 ROL.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  block can accept a beat this cycle
//   in_data    in   [DATA_W-1:0] operand
//   in_amt     in   [AMT_W-1:0]  unsigned shift amount, 0..2*DATA_W-1
//   in_mode    in   [1:0] shift mode
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   out_data   out  [DATA_W-1:0] shifted result
//   out_sticky out  OR of all bits discarded by the shift
//
// Optional feature macro: SHIFTER_PIPE_STICKY_EN
//   defined   : sticky bit is carried through every stage and reported.
//   undefined : no sticky flops; out_sticky is tied to 0.
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. A stage loads when it is empty or when the stage
// after it loads (the last stage: when out_ready). in_ready is stage 0's load
// condition, so it is combinational from out_ready through the chain. Valid
// and data of a held stage never change, which keeps out_data/out_sticky
// stable under backpressure.
// -----------------------------------------------------------------------------
module shifter_pipe #(
  parameter  int DATA_W = 16,
  localparam int LOG_W  = $clog2(DATA_W),
  localparam int AMT_W  = LOG_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sticky
);

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------------
  // Stage-0 pre-step: saturation. Amounts >= DATA_W fully resolve here for
  // LSL/LSR/ASR; the remaining amount is forced to zero so later stages pass
  // the value through. ROL simply drops the amount MSB (amount mod DATA_W).
  // ---------------------------------------------------------------------------
  logic              w_sat;
  logic [DATA_W-1:0] w_pre_data;
  logic [LOG_W-1:0]  w_pre_amt;

  assign w_sat = in_amt[AMT_W-1] && (mode_e'(in_mode) != MODE_ROL);

  always_comb begin
    w_pre_data = in_data;
    w_pre_amt  = in_amt[LOG_W-1:0];
    if (w_sat) begin
      w_pre_amt  = '0;
      w_pre_data = (mode_e'(in_mode) == MODE_ASR) ? {DATA_W{in_data[DATA_W-1]}} : '0;
    end
  end

`ifdef SHIFTER_PIPE_STICKY_EN
  logic w_pre_sticky;
  // A saturated non-rotate shift discards every operand bit.
  assign w_pre_sticky = w_sat && (|in_data);
`endif

  // ---------------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < LOG_W; k++) begin : g_stage
    localparam int SH = 1 << k;

    logic              w_src_valid;
    logic [DATA_W-1:0] w_src_data;
    logic [LOG_W-1:0]  w_src_amt;
    mode_e             w_src_mode;
    logic [DATA_W-1:0] w_nxt_data;
    logic              w_load;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [LOG_W-1:0]  r_amt;
    mode_e             r_mode;

`ifdef SHIFTER_PIPE_STICKY_EN
    logic w_src_sticky;
    logic w_nxt_sticky;
    logic r_sticky;
`endif

    // Source of this stage: the pre-stepped input beat or the previous stage.
    if (k == 0) begin : g_src
      assign w_src_valid  = in_valid;
      assign w_src_data   = w_pre_data;
      assign w_src_amt    = w_pre_amt;
      assign w_src_mode   = mode_e'(in_mode);
`ifdef SHIFTER_PIPE_STICKY_EN
      assign w_src_sticky = w_pre_sticky;
`endif
    end else begin : g_src
      assign w_src_valid  = g_stage[k-1].r_valid;
      assign w_src_data   = g_stage[k-1].r_data;
      assign w_src_amt    = g_stage[k-1].r_amt;
      assign w_src_mode   = g_stage[k-1].r_mode;
`ifdef SHIFTER_PIPE_STICKY_EN
      assign w_src_sticky = g_stage[k-1].r_sticky;
`endif
    end

    // Load when empty or when the downstream register is taking our contents.
    if (k == LOG_W-1) begin : g_ld
      assign w_load = !r_valid || out_ready;
    end else begin : g_ld
      assign w_load = !r_valid || g_stage[k+1].w_load;
    end

    always_comb begin
      w_nxt_data = w_src_data;
      if (w_src_amt[k]) begin
        case (w_src_mode)
          MODE_LSL: w_nxt_data = w_src_data << SH;
          MODE_LSR: w_nxt_data = w_src_data >> SH;
          MODE_ASR: w_nxt_data = DATA_W'($signed(w_src_data) >>> SH);
          default:  w_nxt_data = {w_src_data[DATA_W-SH-1:0], w_src_data[DATA_W-1 -: SH]};
        endcase
      end
    end

    // Payload only updates for a real beat; bubbles just clear the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_amt   <= '0;
        r_mode  <= MODE_LSL;
      end else if (w_load) begin
        r_valid <= w_src_valid;
        if (w_src_valid) begin
          r_data <= w_nxt_data;
          r_amt  <= w_src_amt;
          r_mode <= w_src_mode;
        end
      end
    end

`ifdef SHIFTER_PIPE_STICKY_EN
    // Bits pushed out of the word by this stage's 2^k shift.
    always_comb begin
      w_nxt_sticky = w_src_sticky;
      if (w_src_amt[k]) begin
        case (w_src_mode)
          MODE_LSL:           w_nxt_sticky = w_src_sticky | (|w_src_data[DATA_W-1 -: SH]);
          MODE_LSR, MODE_ASR: w_nxt_sticky = w_src_sticky | (|w_src_data[SH-1:0]);
          default:            w_nxt_sticky = w_src_sticky;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sticky <= 1'b0;
      end else if (w_load && w_src_valid) begin
        r_sticky <= w_nxt_sticky;
      end
    end
`endif
  end

  // The last stage's amount and mode have no consumer.
  logic w_unused;
  assign w_unused = ^{g_stage[LOG_W-1].r_amt, g_stage[LOG_W-1].r_mode};

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = g_stage[0].w_load;
  assign out_valid = g_stage[LOG_W-1].r_valid;
  assign out_data  = g_stage[LOG_W-1].r_data;

`ifdef SHIFTER_PIPE_STICKY_EN
  assign out_sticky = g_stage[LOG_W-1].r_sticky;
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_shifter_pipe
//
// Self-checking bench for shifter_pipe at DATA_W=8 (3 stages, 4-bit amount).
// Expected results come from ref_model, which computes each shift with plain
// wide arithmetic; sticky expectations honour SHIFTER_PIPE_STICKY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shifter_pipe;

  localparam int W  = 8;
  localparam int AW = 4;
  localparam int LAT = 3;

`ifdef SHIFTER_PIPE_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [AW-1:0] in_amt;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_sticky;

  always #5 clk = ~clk;

  shifter_pipe #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entries are {sticky, data}.
  logic [W:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [W:0] ref_model(input logic [W-1:0] d, input int amt,
                                           input logic [1:0] m);
    logic [2*W-1:0] wide;
    logic [W-1:0]   r;
    logic [W-1:0]   ones;
    logic [W-1:0]   fill;
    logic           s;
    ones = '1;
    r    = d;
    s    = 1'b0;
    case (m)
      2'b00: begin
        if (amt >= W) begin r = '0; s = |d; end
        else begin
          wide = {{W{1'b0}}, d} << amt;
          r = wide[W-1:0];
          s = |wide[2*W-1:W];
        end
      end
      2'b01: begin
        if (amt >= W) begin r = '0; s = |d; end
        else begin
          wide = {d, {W{1'b0}}} >> amt;
          r = wide[2*W-1:W];
          s = |wide[W-1:0];
        end
      end
      2'b10: begin
        if (amt >= W) begin r = {W{d[W-1]}}; s = |d; end
        else begin
          wide = {d, {W{1'b0}}} >> amt;
          fill = ~(ones >> amt);
          r = wide[2*W-1:W] | (d[W-1] ? fill : '0);
          s = |wide[W-1:0];
        end
      end
      default: begin
        wide = {d, d} << (amt % W);
        r = wide[2*W-1:W];
        s = 1'b0;
      end
    endcase
    return {STICKY_ON ? s : 1'b0, r};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: applies one cycle of inputs (called at posedge+1), samples the
  // settled handshake state, then advances to the next posedge+1.
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic [AW-1:0] a,
                             input logic [1:0] m, input logic ordy,
                             output logic acc_in, output logic acc_out,
                             output logic [W-1:0] od, output logic os,
                             output logic irdy, output logic ovld);
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_mode   = m;
    out_ready = ordy;
    #1;
    irdy    = in_ready;
    ovld    = out_valid;
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    od      = out_data;
    os      = out_sticky;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_checks++;
    if (out_sticky !== 1'b0) begin n_errors++; $display("FAIL reset_out_sticky: got %b want 0", out_sticky); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready_during: got %b want 1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid_after: got %b want 0", out_valid); end
  endtask

  // Directed vectors, hand-computed: {mode, data, amt, exp_data, exp_sticky}
  localparam int NV = 11;
  logic [1:0]    t_mode [NV] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00};
  logic [W-1:0]  t_data [NV] = '{8'h81, 8'h90, 8'h90, 8'h90, 8'h81, 8'h81, 8'hA5, 8'hFF, 8'h81, 8'h7F, 8'h0F};
  logic [AW-1:0] t_amt  [NV] = '{4'd1,  4'd2,  4'd12, 4'd9,  4'd1,  4'd9,  4'd0,  4'd0,  4'd7,  4'd3,  4'd15};
  logic [W-1:0]  t_exp  [NV] = '{8'h02, 8'hE4, 8'hFF, 8'h00, 8'h03, 8'h03, 8'hA5, 8'hFF, 8'h01, 8'h0F, 8'h00};
  logic          t_stk  [NV] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};

  task automatic test_directed();
    logic acc_in, acc_out, os, irdy, ovld;
    logic [W-1:0] od;
    logic exp_s;
    for (int i = 0; i < NV; i++) begin
      exp_s = STICKY_ON ? t_stk[i] : 1'b0;
      drive_cycle(1'b1, t_data[i], t_amt[i], t_mode[i], 1'b1, acc_in, acc_out, od, os, irdy, ovld);
      n_checks++;
      if (acc_in !== 1'b1) begin n_errors++; $display("FAIL dir%0d_accept: got %b want 1", i, acc_in); end
      for (int c = 1; c <= LAT; c++) begin
        drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, acc_in, acc_out, od, os, irdy, ovld);
        n_checks++;
        if (ovld !== (c == LAT)) begin
          n_errors++;
          $display("FAIL dir%0d_latency cycle %0d: out_valid got %b want %b", i, c, ovld, (c == LAT));
        end
        if (c == LAT) begin
          n_checks++;
          if (od !== t_exp[i]) begin n_errors++; $display("FAIL dir%0d_data: got %h want %h", i, od, t_exp[i]); end
          n_checks++;
          if (os !== exp_s) begin n_errors++; $display("FAIL dir%0d_sticky: got %b want %b", i, os, exp_s); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc_in, acc_out, os, irdy, ovld;
    logic [W-1:0] od, d;
    logic [AW-1:0] a;
    logic [1:0] m;
    logic [W:0] e;
    int n_out;
    n_out = 0;
    exp_q.delete();
    for (int c = 0; c < 20 && n_out < 8; c++) begin
      d = W'($urandom); a = AW'($urandom_range(0, 15)); m = 2'($urandom_range(0, 3));
      drive_cycle(c < 8, d, a, m, 1'b1, acc_in, acc_out, od, os, irdy, ovld);
      if (c < 8) begin
        n_checks++;
        if (irdy !== 1'b1) begin n_errors++; $display("FAIL b2b_in_ready cycle %0d: got %b want 1", c, irdy); end
        if (acc_in) exp_q.push_back(ref_model(d, int'(a), m));
      end
      if (acc_out) begin
        n_checks++;
        if (c !== n_out + LAT) begin n_errors++; $display("FAIL b2b_timing beat %0d: cycle got %0d want %0d", n_out, c, n_out + LAT); end
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL b2b_extra: unexpected result %h", od);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if ({os, od} !== e) begin n_errors++; $display("FAIL b2b_data beat %0d: got %h want %h", n_out, {os, od}, e); end
        end
        n_out++;
      end
    end
    n_checks++;
    if (n_out != 8) begin n_errors++; $display("FAIL b2b_count: got %0d want 8", n_out); end
  endtask

  task automatic test_backpressure();
    logic acc_in, acc_out, os, irdy, ovld;
    logic [W-1:0] od, d, held_d;
    logic [AW-1:0] a;
    logic [1:0] m;
    logic [W:0] e;
    logic held_s, have_held;
    int n_acc, n_out;
    n_acc = 0; n_out = 0; have_held = 1'b0; held_d = '0; held_s = 1'b0; irdy = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      d = W'($urandom); a = AW'($urandom_range(0, 15)); m = 2'($urandom_range(0, 3));
      drive_cycle(1'b1, d, a, m, 1'b0, acc_in, acc_out, od, os, irdy, ovld);
      if (acc_in) begin exp_q.push_back(ref_model(d, int'(a), m)); n_acc++; end
      if (ovld && have_held) begin
        n_checks++;
        if ({os, od} !== {held_s, held_d}) begin
          n_errors++; $display("FAIL bp_stable cycle %0d: got %h want %h", c, {os, od}, {held_s, held_d});
        end
      end
      if (ovld && !have_held) begin have_held = 1'b1; held_d = od; held_s = os; end
    end
    n_checks++;
    if (n_acc != 3) begin n_errors++; $display("FAIL bp_fill: accepted got %0d want 3", n_acc); end
    n_checks++;
    if (irdy !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready_full: got %b want 0", irdy); end
    n_checks++;
    if (have_held !== 1'b1) begin n_errors++; $display("FAIL bp_out_valid: got %b want 1", have_held); end
    for (int c = 0; c < 10 && n_out < 3; c++) begin
      drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, acc_in, acc_out, od, os, irdy, ovld);
      if (acc_out) begin
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL bp_extra: unexpected result %h", od);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if ({os, od} !== e) begin n_errors++; $display("FAIL bp_drain beat %0d: got %h want %h", n_out, {os, od}, e); end
        end
        n_out++;
      end
    end
    n_checks++;
    if (n_out != 3) begin n_errors++; $display("FAIL bp_drain_count: got %0d want 3", n_out); end
  endtask

  task automatic test_random();
    localparam int NB = 10000;
    logic acc_in, acc_out, os, irdy, ovld, v, ordy;
    logic [W-1:0] od, d, prev_d;
    logic [AW-1:0] a;
    logic [1:0] m;
    logic [W:0] e;
    logic prev_s, prev_stall;
    int n_sent, n_out, n_bad;
    n_sent = 0; n_out = 0; n_bad = 0; prev_stall = 1'b0; prev_d = '0; prev_s = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 40000 && n_out < NB && n_bad < 20; c++) begin
      v    = (n_sent < NB) && ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 65);
      d = W'($urandom); a = AW'($urandom_range(0, 15)); m = 2'($urandom_range(0, 3));
      drive_cycle(v, d, a, m, ordy, acc_in, acc_out, od, os, irdy, ovld);
      if (prev_stall) begin
        n_checks++;
        if (ovld !== 1'b1 || {os, od} !== {prev_s, prev_d}) begin
          n_errors++; n_bad++;
          $display("FAIL rnd_stable cycle %0d: got v=%b %h want v=1 %h", c, ovld, {os, od}, {prev_s, prev_d});
        end
      end
      prev_stall = ovld && !ordy;
      prev_d = od; prev_s = os;
      if (acc_in) begin exp_q.push_back(ref_model(d, int'(a), m)); n_sent++; end
      if (acc_out) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; n_bad++; $display("FAIL rnd_extra cycle %0d: unexpected result %h", c, od);
        end else begin
          e = exp_q.pop_front();
          if ({os, od} !== e) begin
            n_errors++; n_bad++;
            $display("FAIL rnd_data beat %0d: got %h want %h", n_out, {os, od}, e);
          end
        end
        n_out++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (n_out != NB) begin n_errors++; $display("FAIL rnd_count: got %0d want %0d", n_out, NB); end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL rnd_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    logic acc_in, acc_out, os, irdy, ovld;
    logic [W-1:0] od;
    logic [W:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, W'($urandom), AW'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b0,
                  acc_in, acc_out, od, os, irdy, ovld);
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rst_mid_preload: out_valid got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_async: out_valid got %b want 0", out_valid); end
    n_checks++;
    if (out_data !== '0) begin n_errors++; $display("FAIL rst_mid_data: got %h want 00", out_data); end
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, acc_in, acc_out, od, os, irdy, ovld);
      n_checks++;
      if (ovld !== 1'b0) begin n_errors++; $display("FAIL rst_mid_ghost cycle %0d: out_valid got %b want 0", c, ovld); end
    end
    e = ref_model(8'h81, 1, 2'b11);
    drive_cycle(1'b1, 8'h81, 4'd1, 2'b11, 1'b1, acc_in, acc_out, od, os, irdy, ovld);
    n_checks++;
    if (acc_in !== 1'b1) begin n_errors++; $display("FAIL rst_mid_accept: got %b want 1", acc_in); end
    for (int c = 1; c <= LAT; c++) begin
      drive_cycle(1'b0, '0, '0, 2'b00, 1'b1, acc_in, acc_out, od, os, irdy, ovld);
      n_checks++;
      if (ovld !== (c == LAT)) begin
        n_errors++; $display("FAIL rst_mid_latency cycle %0d: out_valid got %b want %b", c, ovld, (c == LAT));
      end
    end
    n_checks++;
    if ({os, od} !== e) begin n_errors++; $display("FAIL rst_mid_data_after: got %h want %h", {os, od}, e); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
